// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - Command/response to APB requester, one transfer outstanding.
// Optional ACCESS-phase abort is built only when APB_TIMEOUT_EN is defined.
module apb_req_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [20:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [20:0] req_paddr,
    output logic        req_pwrite,
    output logic        req_psel,
    output logic        req_penable,
    output logic [15:0] req_pwdata,
    input  logic        req_pready,
    input  logic [15:0] req_prdata,
    input  logic        req_pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic cmd_fire;
    logic rsp_fire;
    logic access_done;
    logic timeout_hit;

    assign cmd_fire    = cmd_valid && (state == IDLE);
    assign rsp_fire    = rsp_ready && (state == RESP);
    assign access_done = (state == ACCESS) && req_pready;

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] timeout_cnt;

    // The abort fires on the ACCESS cycle that would bring the wait count to
    // TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES ACCESS cycles are spent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_cnt <= 16'd0;
        end else if (cmd_fire || (state == SETUP)) begin
            timeout_cnt <= 16'd0;
        end else if ((state == ACCESS) && !req_pready) begin
            timeout_cnt <= timeout_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == ACCESS) && !req_pready && (timeout_cnt == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        req_psel    = 1'b0;
        req_penable = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                req_psel   = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                req_psel    = 1'b1;
                req_penable = 1'b1;
                if (req_pready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields hold the last accepted command until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_paddr  <= 21'd0;
            req_pwrite <= 1'b0;
            req_pwdata <= 16'd0;
        end else if (cmd_fire) begin
            req_paddr  <= cmd_addr;
            req_pwrite <= cmd_write;
            req_pwdata <= cmd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_rdata   <= 16'd0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (access_done) begin
            rsp_rdata   <= req_pwrite ? 16'd0 : req_prdata;
            rsp_err     <= req_pslverr;
            rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
            rsp_rdata   <= 16'd0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

    logic unused_rsp_fire;
    assign unused_rsp_fire = rsp_fire;

endmodule

// File: tb/tb_apb_req_master.sv
// tb/tb_apb_req_master.sv - Directed self-checking bench for apb_req_master.
module tb_apb_req_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [20:0] cmd_addr;
    logic        cmd_write;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [20:0] req_paddr;
    logic        req_pwrite;
    logic        req_psel;
    logic        req_penable;
    logic [15:0] req_pwdata;
    logic        req_pready;
    logic [15:0] req_prdata;
    logic        req_pslverr;

    int tests = 0;
    int fails = 0;

    apb_req_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .req_paddr(req_paddr), .req_pwrite(req_pwrite), .req_psel(req_psel),
        .req_penable(req_penable), .req_pwdata(req_pwdata),
        .req_pready(req_pready), .req_prdata(req_prdata), .req_pslverr(req_pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 21'h1FFFF; cmd_write = 1'b1;
        cmd_wdata = 16'hFFFF; rsp_ready = 1'b0; req_pready = 1'b0;
        req_prdata = 16'h0; req_pslverr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tests++; if (req_psel !== 1'b0) begin fails++; $display("FAIL rst_psel got %b exp 0", req_psel); end
        tests++; if (req_penable !== 1'b0) begin fails++; $display("FAIL rst_penable got %b exp 0", req_penable); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
        tests++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 18'd0) begin fails++; $display("FAIL rst_rsp got %h exp 0", {rsp_rdata, rsp_err, rsp_timeout}); end
        tests++; if ({req_paddr, req_pwrite, req_pwdata} !== 38'd0) begin fails++; $display("FAIL rst_req got %h exp 0", {req_paddr, req_pwrite, req_pwdata}); end
    endtask

    task automatic test_zero_wait_write();
        cmd_valid = 1'b1; cmd_addr = 21'h10004; cmd_write = 1'b1; cmd_wdata = 16'hA5A5;
        req_pready = 1'b1; req_prdata = 16'hDEAD; req_pslverr = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tests++; if ({req_psel, req_penable, cmd_ready} !== 3'b100) begin fails++; $display("FAIL wr_setup got %b exp 100", {req_psel, req_penable, cmd_ready}); end
        tests++; if ({req_paddr, req_pwrite, req_pwdata} !== {21'h10004, 1'b1, 16'hA5A5}) begin fails++; $display("FAIL wr_setup_req got %h exp %h", {req_paddr, req_pwrite, req_pwdata}, {21'h10004, 1'b1, 16'hA5A5}); end
        tick();
        tests++; if ({req_psel, req_penable, rsp_valid} !== 3'b110) begin fails++; $display("FAIL wr_access got %b exp 110", {req_psel, req_penable, rsp_valid}); end
        tests++; if ({req_paddr, req_pwrite, req_pwdata} !== {21'h10004, 1'b1, 16'hA5A5}) begin fails++; $display("FAIL wr_access_req got %h", {req_paddr, req_pwrite, req_pwdata}); end
        tick();
        tests++; if ({rsp_valid, req_psel, req_penable, cmd_ready} !== 4'b1000) begin fails++; $display("FAIL wr_resp got %b exp 1000", {rsp_valid, req_psel, req_penable, cmd_ready}); end
        tests++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 18'd0) begin fails++; $display("FAIL wr_rsp_data got %h exp 0", {rsp_rdata, rsp_err, rsp_timeout}); end
        tests++; if (req_paddr !== 21'h10004) begin fails++; $display("FAIL wr_paddr_hold got %h exp 10004", req_paddr); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL wr_idle got %b exp 01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_wait_read();
        int pen_cnt = 0;
        cmd_valid = 1'b1; cmd_addr = 21'h00010; cmd_write = 1'b0; cmd_wdata = 16'h0;
        req_pready = 1'b0; req_prdata = 16'hBEEF;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) begin
            if (req_penable === 1'b1) begin
                pen_cnt++;
                req_pready = (pen_cnt == 4);
                req_prdata = (pen_cnt == 4) ? 16'h1234 : 16'hBEEF;
            end else begin
                req_pready = 1'b0;
            end
            tick();
        end
        req_pready = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rd_wait_rsp_valid got %b exp 1", rsp_valid); end
        tests++; if (pen_cnt != 4) begin fails++; $display("FAIL rd_wait_penable_cycles got %0d exp 4", pen_cnt); end
        tests++; if ({rsp_rdata, rsp_err, rsp_timeout} !== {16'h1234, 2'b00}) begin fails++; $display("FAIL rd_wait_rsp got %h exp %h", {rsp_rdata, rsp_err, rsp_timeout}, {16'h1234, 2'b00}); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_slverr_hold();
        cmd_valid = 1'b1; cmd_addr = 21'h00020; cmd_write = 1'b0;
        req_pready = 1'b1; req_prdata = 16'hFFFF; req_pslverr = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        tests++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 16'hFFFF, 2'b10}) begin fails++; $display("FAIL err_rsp got %h exp %h", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, 16'hFFFF, 2'b10}); end
        req_prdata = 16'h0; req_pslverr = 1'b0; req_pready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready} !== {1'b1, 16'hFFFF, 2'b10, 1'b0}) begin
                fails++; $display("FAIL err_hold_%0d got %h exp %h", i, {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready}, {1'b1, 16'hFFFF, 2'b10, 1'b0});
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL err_release got %b exp 01", {rsp_valid, cmd_ready}); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++; if ({rsp_valid, req_psel} !== 2'b00) begin fails++; $display("FAIL stray_rsp_ready got %b exp 00", {rsp_valid, req_psel}); end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_addr = 21'h00044; cmd_write = 1'b0; req_pready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tests++; if (req_penable !== 1'b1) begin fails++; $display("FAIL rstmid_in_access got %b exp 1", req_penable); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++; if ({req_psel, req_penable, rsp_valid, cmd_ready} !== 4'b0001) begin fails++; $display("FAIL rstmid_abort got %b exp 0001", {req_psel, req_penable, rsp_valid, cmd_ready}); end
        cmd_valid = 1'b1; cmd_addr = 21'h1F0F0; cmd_write = 1'b1; cmd_wdata = 16'h5A5A;
        req_pready = 1'b1; req_prdata = 16'h1111;
        tick();
        cmd_valid = 1'b0;
        tests++; if ({req_psel, req_paddr, req_pwdata} !== {1'b1, 21'h1F0F0, 16'h5A5A}) begin fails++; $display("FAIL rstmid_wr_setup got %h", {req_psel, req_paddr, req_pwdata}); end
        tick(); tick();
        tests++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 16'h0, 2'b00}) begin fails++; $display("FAIL rstmid_wr_rsp got %h exp %h", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, 16'h0, 2'b00}); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int hs[$];
        int overlap = 0;
        cmd_valid = 1'b1; cmd_addr = 21'h00100; cmd_write = 1'b1; cmd_wdata = 16'h0F0F;
        rsp_ready = 1'b1; req_pready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cmd_ready === 1'b1) hs.push_back(cyc);
            if (req_psel === 1'b1 && (cmd_ready === 1'b1 || rsp_valid === 1'b1)) overlap++;
            tick();
        end
        cmd_valid = 1'b0;
        tests++; if (hs.size() < 2) begin fails++; $display("FAIL b2b_handshakes got %0d exp >=2", hs.size()); end
        else begin
            tests++; if (hs[1] - hs[0] != 4) begin fails++; $display("FAIL b2b_spacing got %0d exp 4", hs[1] - hs[0]); end
        end
        tests++; if (overlap != 0) begin fails++; $display("FAIL b2b_overlap got %0d exp 0", overlap); end
        for (int i = 0; i < 10 && !(cmd_ready === 1'b1 && rsp_valid === 1'b0); i++) tick();
        rsp_ready = 1'b0;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_drain got %b exp 1", cmd_ready); end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            int pen_cnt = 0;
            cmd_valid = 1'b1; cmd_addr = 21'h00200; cmd_write = 1'b0;
            req_pready = 1'b0; req_prdata = 16'h7777; req_pslverr = 1'b0;
            tick();
            cmd_valid = 1'b0;
            for (int i = 0; i < 30 && rsp_valid !== 1'b1; i++) begin
                if (req_penable === 1'b1) pen_cnt++;
                req_pready = (pass == 1) && (pen_cnt == 8);
                tick();
            end
            req_pready = 1'b0;
            tests++; if (pen_cnt != 8) begin fails++; $display("FAIL to_access_cycles_%0d got %0d exp 8", pass, pen_cnt); end
            if (pass == 0) begin
                tests++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 16'h0, 2'b11}) begin fails++; $display("FAIL to_abort got %h exp %h", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, 16'h0, 2'b11}); end
            end else begin
                tests++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 16'h7777, 2'b00}) begin fails++; $display("FAIL to_late_ready got %h exp %h", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, 16'h7777, 2'b00}); end
            end
            tests++; if ({req_psel, req_penable} !== 2'b00) begin fails++; $display("FAIL to_bus_idle_%0d got %b exp 00", pass, {req_psel, req_penable}); end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slverr_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_req_master.md
APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023, number of ACCESS cycles waited for req_pready before abort (range 1..65535; used only when APB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-006 cmd_addr  input  21  APB address.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_wdata  input  16  write data.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
REQ-011 rsp_rdata  output  16  read data; 0 for writes.
REQ-012 rsp_err  output  1  slave error or timeout.
REQ-013 rsp_timeout  output  1  transfer aborted by timeout.
REQ-014 req_paddr  output  21,  req_pwrite  output  1,  req_psel  output  1,  req_penable  output  1,  req_pwdata  output  16  APB request to the register slave.
REQ-015 req_pready  input  1,  req_prdata  input  16,  req_pslverr  input  1  APB completion from the slave.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS, RESP; exactly one transfer outstanding.
REQ-017 IDLE: cmd_ready=1, psel=0, penable=0; on handshake, register addr/write/wdata and go to SETUP next cycle.
REQ-018 SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
REQ-019 ACCESS: psel=1, penable=1; remain until req_pready=1; req_pready sampled only in ACCESS.
REQ-020 ACCESS with req_pready=1: capture req_prdata (forced to 0 for writes) into rsp_rdata and req_pslverr into rsp_err; next cycle psel=0, penable=0, state RESP.
REQ-021 req_paddr, req_pwrite, req_pwdata stable from SETUP through the final ACCESS cycle; value outside SETUP/ACCESS is the last command, unchanged.
REQ-022 RESP: rsp_valid=1, response outputs held stable until rsp_ready=1; on handshake go to IDLE next cycle.
REQ-023 cmd_ready=0 in SETUP, ACCESS, RESP; a new command is never accepted in the same cycle a response completes (minimum 4 cycles command-to-command with zero-wait slave).
REQ-024 Zero-wait slave (pready=1 on first ACCESS cycle): cmd handshake at cycle N -> SETUP N+1, ACCESS N+2, rsp_valid N+3.
REQ-025 rsp_ready asserted while rsp_valid=0 is ignored; cmd_valid deasserted before handshake has no effect.

Reset
REQ-026 rst_n=0 at rising edge: state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, req_psel=0, req_penable=0, req_pwrite=0, req_paddr=0, req_pwdata=0, timeout counter=0.
REQ-027 Reset mid-transfer (any state) aborts it silently: no response produced; psel/penable low the cycle after reset is sampled.

Configuration
REQ-028 Macro APB_TIMEOUT_EN: when defined, a 16-bit counter clears on SETUP entry and increments each ACCESS cycle with req_pready=0.
REQ-029 With APB_TIMEOUT_EN defined, counter reaching TIMEOUT_CYCLES with req_pready=0 forces RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel/penable deasserted next cycle; pready arriving on that same cycle wins (normal completion).
REQ-030 Without APB_TIMEOUT_EN, no counter is built, ACCESS waits indefinitely, rsp_timeout is tied to 0.

Verification
REQ-031 Write addr 0x1_0004 data 0xA5A5, slave pready=1 immediately -> SETUP/ACCESS one cycle each with paddr=0x10004, pwdata=0xA5A5, pwrite=1; rsp_valid 3 cycles after handshake, rsp_err=0, rsp_rdata=0.
REQ-032 Read addr 0x00010, slave 3 wait states then prdata=0x1234 -> penable high 4 cycles, rsp_rdata=0x1234, rsp_err=0.
REQ-033 Read with pslverr=1 and prdata=0xFFFF -> rsp_err=1, rsp_timeout=0, rsp_rdata=0xFFFF; rsp_ready held low 5 cycles -> response outputs stable, cmd_ready=0 throughout.
REQ-034 APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never ready -> exactly 8 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0; repeat with pready=1 on the 8th cycle -> rsp_timeout=0.
REQ-035 rst_n=0 for one cycle during ACCESS -> psel=0, penable=0, rsp_valid=0 next cycle; following write command completes normally.
REQ-036 Back-to-back commands with cmd_valid held high and rsp_ready=1 -> second handshake exactly 4 cycles after the first, no overlap of psel windows.
